// File: rtl/steer_pkg.sv
// steer_pkg: shared state encoding and default thresholds for the steering-enable controller
package steer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STEADY = 2'd2,
    GRACE  = 2'd3
  } state_t;

  localparam logic [11:0] MIN_RIDER_WT_D = 12'h200;
  localparam logic [11:0] HYST_D         = 12'h040;
  localparam int          SETTLE_CNT_D   = 65_000_000;
  localparam int          GRACE_CNT_D    = 12_500_000;

endpackage

// File: rtl/ld_cmp.sv
// ld_cmp: combinational weight and balance comparisons on held load-cell samples
module ld_cmp
  import steer_pkg::*;
#(
  parameter int              LD_W         = 12,
  parameter logic [LD_W-1:0] MIN_RIDER_WT = LD_W'(MIN_RIDER_WT_D),
  parameter logic [LD_W-1:0] HYST         = LD_W'(HYST_D)
) (
  input  logic [LD_W-1:0] lft,
  input  logic [LD_W-1:0] rght,
  output logic            sum_gt_min,
  output logic            sum_lt_min,
  output logic            diff_gt_1_4,
  output logic            diff_gt_15_16
);

  // Thresholds carry one extra bit so MIN+HYST cannot overflow
  localparam logic [LD_W:0] HI    = {1'b0, MIN_RIDER_WT} + {1'b0, HYST};
  localparam logic [LD_W:0] LO    = {1'b0, MIN_RIDER_WT} - {1'b0, HYST};
  localparam bit            LT_EN = HYST < MIN_RIDER_WT;

  logic [LD_W:0]   sum;
  logic [LD_W-1:0] diff;

  assign sum           = {1'b0, lft} + {1'b0, rght};
  assign diff          = (lft >= rght) ? lft - rght : rght - lft;
  assign sum_gt_min    = sum > HI;
  assign sum_lt_min    = LT_EN && (sum < LO);
  assign diff_gt_1_4   = {1'b0, diff} > (sum >> 2);
  assign diff_gt_15_16 = {1'b0, diff} > (sum - (sum >> 4));

endmodule

// File: rtl/steer_en_ctrl.sv
// steer_en_ctrl: rider-presence FSM gating steering with settle and grace timing
module steer_en_ctrl
  import steer_pkg::*;
#(
  parameter int              LD_W         = 12,
  parameter logic [LD_W-1:0] MIN_RIDER_WT = LD_W'(MIN_RIDER_WT_D),
  parameter logic [LD_W-1:0] HYST         = LD_W'(HYST_D),
  parameter int              TMR_W        = 26,
  parameter int              SETTLE_CNT   = SETTLE_CNT_D,
  parameter int              GRACE_CNT    = GRACE_CNT_D
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  input  logic            ld_vld,
  output logic            en_steer,
  output logic            rider_off,
  output logic [1:0]      state_o
);

  state_t            state, nxt;
  logic [LD_W-1:0]   lft_q, rght_q;
  logic [TMR_W-1:0]  tmr;
  logic              clr_tmr, settle_full, grace_full;
  logic              sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16;

  ld_cmp #(
    .LD_W        (LD_W),
    .MIN_RIDER_WT(MIN_RIDER_WT),
    .HYST        (HYST)
  ) u_cmp (
    .lft          (lft_q),
    .rght         (rght_q),
    .sum_gt_min   (sum_gt_min),
    .sum_lt_min   (sum_lt_min),
    .diff_gt_1_4  (diff_gt_1_4),
    .diff_gt_15_16(diff_gt_15_16)
  );

  assign settle_full = tmr == TMR_W'(SETTLE_CNT - 1);
  assign grace_full  = tmr >= TMR_W'(GRACE_CNT - 1);
  assign state_o     = state;

  // Hold the latest strobed load-cell samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_q  <= '0;
      rght_q <= '0;
    end else if (ld_vld) begin
      lft_q  <= lft_ld;
      rght_q <= rght_ld;
    end
  end

  // Shared settle/grace timer; saturates so it never wraps into a false settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmr <= '0;
    else        tmr <= clr_tmr ? '0 : (&tmr ? tmr : tmr + TMR_W'(1));
  end

  // Next-state and timer-clear decode; in-band weight falls through to a hold
  always_comb begin
    nxt     = state;
    clr_tmr = 1'b0;
    unique case (state)
      IDLE:   if (sum_gt_min) begin nxt = WAIT; clr_tmr = 1'b1; end
      WAIT:   if (sum_lt_min) nxt = IDLE;
              else if (diff_gt_1_4) clr_tmr = 1'b1;
              else if (settle_full) nxt = STEADY;
      STEADY: if (sum_lt_min) begin nxt = GRACE; clr_tmr = 1'b1; end
              else if (diff_gt_15_16) begin nxt = WAIT; clr_tmr = 1'b1; end
      GRACE:  if (sum_gt_min) nxt = STEADY;
              else if (grace_full || diff_gt_15_16) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State register with Moore outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      en_steer  <= 1'b0;
      rider_off <= 1'b1;
    end else begin
      state     <= nxt;
      en_steer  <= (nxt == STEADY) || (nxt == GRACE);
      rider_off <= nxt == IDLE;
    end
  end

endmodule

// File: tb/tb_steer_en_ctrl.sv
// tb_steer_en_ctrl: vector-table and scoreboard bench for the steering-enable controller
module tb_steer_en_ctrl;
  import steer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] lft_ld = '0;
  logic [11:0] rght_ld = '0;
  logic        ld_vld = 1'b0;
  logic        en_steer, rider_off;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] l;
    logic [11:0] r;
    int          cyc;
    logic [1:0]  st;
  } vec_t;

  vec_t       tbl[$];
  logic [1:0] exp_q[$];

  always #10 clk = ~clk;

  steer_en_ctrl #(
    .LD_W        (12),
    .MIN_RIDER_WT(12'h200),
    .HYST        (12'h040),
    .TMR_W       (26),
    .SETTLE_CNT  (16),
    .GRACE_CNT   (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lft_ld   (lft_ld),
    .rght_ld  (rght_ld),
    .ld_vld   (ld_vld),
    .en_steer (en_steer),
    .rider_off(rider_off),
    .state_o  (state_o)
  );

  // Pop the oldest expected state and compare all three outputs against it
  task automatic check(input string name);
    logic [1:0] e;
    logic       e_en, e_off;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e     = exp_q.pop_front();
    e_en  = (e == 2'd2) || (e == 2'd3);
    e_off = e == 2'd0;
    if (state_o !== e || en_steer !== e_en || rider_off !== e_off) begin
      errors++;
      $display("FAIL %s: got state=%0d en=%b off=%b, need state=%0d en=%b off=%b",
               name, state_o, en_steer, rider_off, e, e_en, e_off);
    end
  endtask

  // Strobe one sample from a negedge, run cyc rising edges, sample on the following negedge
  task automatic apply(input vec_t v, input int idx);
    lft_ld  = v.l;
    rght_ld = v.r;
    ld_vld  = 1'b1;
    exp_q.push_back(v.st);
    @(posedge clk);
    #1 ld_vld = 1'b0;
    repeat (v.cyc - 1) @(posedge clk);
    @(negedge clk);
    check($sformatf("vec%0d", idx));
  endtask

  initial begin
    tbl.push_back('{12'h000, 12'h000,  2, 2'd0});
    tbl.push_back('{12'h120, 12'h120,  3, 2'd0});
    tbl.push_back('{12'h150, 12'h150,  2, 2'd1});
    tbl.push_back('{12'h150, 12'h150, 10, 2'd1});
    tbl.push_back('{12'h200, 12'h0A0, 20, 2'd1});
    tbl.push_back('{12'h150, 12'h150, 16, 2'd1});
    tbl.push_back('{12'h150, 12'h150,  1, 2'd2});
    tbl.push_back('{12'h100, 12'h100, 30, 2'd2});
    tbl.push_back('{12'h0E0, 12'h0E0, 12, 2'd2});
    tbl.push_back('{12'h0C0, 12'h0C0,  2, 2'd3});
    tbl.push_back('{12'h0C0, 12'h0C0,  3, 2'd3});
    tbl.push_back('{12'h150, 12'h150,  2, 2'd2});
    tbl.push_back('{12'h0C0, 12'h0C0,  2, 2'd3});
    tbl.push_back('{12'h0C0, 12'h0C0,  7, 2'd3});
    tbl.push_back('{12'h0C0, 12'h0C0,  1, 2'd0});
    tbl.push_back('{12'h100, 12'h100,  5, 2'd0});
    tbl.push_back('{12'h150, 12'h150,  2, 2'd1});
    tbl.push_back('{12'h150, 12'h150, 16, 2'd2});
    tbl.push_back('{12'h0C0, 12'h000,  2, 2'd3});
    tbl.push_back('{12'h0C0, 12'h000,  1, 2'd0});
    tbl.push_back('{12'h150, 12'h150,  2, 2'd1});
    tbl.push_back('{12'h150, 12'h150, 16, 2'd2});
    tbl.push_back('{12'h2A0, 12'h000,  2, 2'd1});

    repeat (3) @(negedge clk);
    exp_q.push_back(2'd0);
    check("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    #5 rst_n = 1'b0;
    #1;
    exp_q.push_back(2'd0);
    check("async_rst");
    @(negedge clk);
    exp_q.push_back(2'd0);
    check("rst_hold");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
